// File: rtl/lsu_stage.sv
// lsu_stage: single-outstanding load/store stage between execute and writeback.
// Optional misaligned-access trap enabled by defining LSU_MISALIGN_TRAP_EN.
module lsu_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_addr,
  input  logic [31:0] in_wdata,
  input  logic [3:0]  in_func,
  input  logic [4:0]  in_rd,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_addr,
  output logic        mem_wen,
  output logic [3:0]  mem_wmask,
  output logic [31:0] mem_wdata,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [4:0]  out_rd,
  output logic        out_we,
  output logic        out_err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  logic [3:0]  r_func;
  logic [4:0]  r_rd;
  logic [1:0]  r_lane;
  logic        r_in_ready;
  logic        r_mem_req_valid;
  logic [31:0] r_mem_addr;
  logic        r_mem_wen;
  logic [3:0]  r_mem_wmask;
  logic [31:0] r_mem_wdata;
  logic        r_out_valid;
  logic [31:0] r_out_data;
  logic [4:0]  r_out_rd;
  logic        r_out_we;
  logic        r_out_err;

  logic        w_accept;
  logic        w_rsp;
  logic        w_misalign;
  logic [3:0]  w_wmask;
  logic [31:0] w_wdata;
  logic [31:0] w_load;

  function automatic logic [3:0] f_store_mask(input logic [1:0] size, input logic [1:0] lane);
    case (size)
      2'b00:   f_store_mask = 4'b0001 << lane;
      2'b01:   f_store_mask = 4'b0011 << {lane[1], 1'b0};
      default: f_store_mask = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] f_store_data(input logic [1:0] size, input logic [31:0] wd);
    case (size)
      2'b00:   f_store_data = {4{wd[7:0]}};
      2'b01:   f_store_data = {2{wd[15:0]}};
      default: f_store_data = wd;
    endcase
  endfunction

  // Lane select ignores the low bits a naturally aligned access would not use.
  function automatic logic [31:0] f_load_ext(input logic is_unsigned, input logic [1:0] size,
                                             input logic [1:0] lane, input logic [31:0] rd);
    logic [7:0]  b;
    logic [15:0] h;
    b = rd[{lane, 3'b000} +: 8];
    h = rd[{lane[1], 4'b0000} +: 16];
    case (size)
      2'b00:   f_load_ext = is_unsigned ? {24'd0, b} : {{24{b[7]}}, b};
      2'b01:   f_load_ext = is_unsigned ? {16'd0, h} : {{16{h[15]}}, h};
      default: f_load_ext = rd;
    endcase
  endfunction

`ifdef LSU_MISALIGN_TRAP_EN
  // Misalignment check on the incoming access.
  always_comb begin
    w_misalign = 1'b0;
    case (in_func[1:0])
      2'b00:   w_misalign = 1'b0;
      2'b01:   w_misalign = in_addr[0];
      default: w_misalign = (in_addr[1:0] != 2'b00);
    endcase
  end
`else
  assign w_misalign = 1'b0;
`endif

  assign w_accept = (r_state == S_IDLE) && in_valid;
  assign w_rsp    = (r_state == S_WAIT) && mem_rsp_valid;
  assign w_wmask  = f_store_mask(in_func[1:0], in_addr[1:0]);
  assign w_wdata  = f_store_data(in_func[1:0], in_wdata);
  assign w_load   = f_load_ext(r_func[2], r_func[1:0], r_lane, mem_rdata);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (in_valid) begin
          w_state_nxt = w_misalign ? S_DONE : S_REQ;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_REQ: begin
        if (mem_req_ready) begin
          w_state_nxt = S_WAIT;
        end else begin
          w_state_nxt = S_REQ;
        end
      end
      S_WAIT: begin
        if (mem_rsp_valid) begin
          w_state_nxt = S_DONE;
        end else begin
          w_state_nxt = S_WAIT;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_DONE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Handshake flags registered from the next state so they line up with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_in_ready      <= 1'b1;
      r_mem_req_valid <= 1'b0;
      r_out_valid     <= 1'b0;
    end else begin
      r_in_ready      <= (w_state_nxt == S_IDLE);
      r_mem_req_valid <= (w_state_nxt == S_REQ);
      r_out_valid     <= (w_state_nxt == S_DONE);
    end
  end

  // Access capture, bus fields and writeback result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_func      <= 4'd0;
      r_rd        <= 5'd0;
      r_lane      <= 2'd0;
      r_mem_addr  <= 32'd0;
      r_mem_wen   <= 1'b0;
      r_mem_wmask <= 4'd0;
      r_mem_wdata <= 32'd0;
      r_out_data  <= 32'd0;
      r_out_rd    <= 5'd0;
      r_out_we    <= 1'b0;
      r_out_err   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_func <= in_func;
        r_rd   <= in_rd;
        r_lane <= in_addr[1:0];
      end
      if (w_accept && !w_misalign) begin
        r_mem_addr  <= {in_addr[31:2], 2'b00};
        r_mem_wen   <= in_func[3];
        r_mem_wmask <= in_func[3] ? w_wmask : 4'd0;
        r_mem_wdata <= in_func[3] ? w_wdata : 32'd0;
      end
      if (w_accept && w_misalign) begin
        r_out_data <= 32'd0;
        r_out_rd   <= in_rd;
        r_out_we   <= 1'b0;
        r_out_err  <= 1'b1;
      end else if (w_rsp) begin
        r_out_data <= r_func[3] ? 32'd0 : w_load;
        r_out_rd   <= r_rd;
        r_out_we   <= ~r_func[3];
        r_out_err  <= 1'b0;
      end
    end
  end

  assign in_ready      = r_in_ready;
  assign mem_req_valid = r_mem_req_valid;
  assign mem_addr      = r_mem_addr;
  assign mem_wen       = r_mem_wen;
  assign mem_wmask     = r_mem_wmask;
  assign mem_wdata     = r_mem_wdata;
  assign out_valid     = r_out_valid;
  assign out_data      = r_out_data;
  assign out_rd        = r_out_rd;
  assign out_we        = r_out_we;
  assign out_err       = r_out_err;

endmodule

// File: tb/tb_lsu_stage.sv
// Self-checking bench for lsu_stage: directed table, corner sequences, randomized vs reference model.
module tb_lsu_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_addr = 32'd0;
  logic [31:0] in_wdata = 32'd0;
  logic [3:0]  in_func = 4'd0;
  logic [4:0]  in_rd = 5'd0;
  logic        mem_req_valid;
  logic        mem_req_ready = 1'b0;
  logic [31:0] mem_addr;
  logic        mem_wen;
  logic [3:0]  mem_wmask;
  logic [31:0] mem_wdata;
  logic        mem_rsp_valid = 1'b0;
  logic [31:0] mem_rdata = 32'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic [4:0]  out_rd;
  logic        out_we;
  logic        out_err;

  int total = 0;
  int bad = 0;

  lsu_stage dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr), .in_wdata(in_wdata),
    .in_func(in_func), .in_rd(in_rd),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
    .mem_wen(mem_wen), .mem_wmask(mem_wmask), .mem_wdata(mem_wdata),
    .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_rd(out_rd),
    .out_we(out_we), .out_err(out_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] mem_addr;
    logic [3:0]  wmask;
    logic [31:0] wdata;
    logic [31:0] data;
    logic        we;
    logic        err;
  } exp_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] wd;
    logic [3:0]  f;
    logic [4:0]  rd;
    logic [31:0] rdata;
    exp_t        e;
    int          req_lat;
    int          out_lat;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", nm, act, exp);
    end
  endtask

  // Reference: access width n bytes at byte offset off inside the word.
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] wd,
                                 input logic [3:0] f, input logic [31:0] rdata);
    exp_t   e;
    int     n;
    int     off;
    longint v;
    n = (f[1:0] == 2'b00) ? 1 : ((f[1:0] == 2'b01) ? 2 : 4);
    off = (n == 1) ? int'(a[1:0]) : ((n == 2) ? 2 * int'(a[1]) : 0);
    e.mem_addr = a & 32'hFFFF_FFFC;
    e.wmask = 4'd0;
    e.wdata = 32'd0;
    e.data = 32'd0;
    e.we = 1'b0;
    e.err = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
    e.err = (int'(a[1:0]) % n) != 0;
`endif
    if (e.err) begin
      e.mem_addr = 32'd0;
    end else if (f[3]) begin
      for (int i = 0; i < n; i++) e.wmask[off + i] = 1'b1;
      for (int i = 0; i < 4; i++) e.wdata[8 * i +: 8] = wd[8 * (i % n) +: 8];
    end else begin
      v = (longint'(rdata) >> (8 * off)) & ((64'd1 << (8 * n)) - 64'd1);
      if (!f[2] && n < 4 && v[8 * n - 1]) v = v - (64'sd1 <<< (8 * n));
      e.data = v[31:0];
      e.we = 1'b1;
    end
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_txn(input string tag, input logic [31:0] a, input logic [31:0] wd,
                        input logic [3:0] f, input logic [4:0] rd, input logic [31:0] rdata,
                        input exp_t e, input int req_lat, input int rsp_lat, input int out_lat);
    chk({tag, ".idle_in_ready"}, in_ready, 1);
    in_valid = 1'b1; in_addr = a; in_wdata = wd; in_func = f; in_rd = rd;
    tick();
    in_valid = 1'b0; in_addr = $urandom; in_wdata = $urandom; in_func = 4'($urandom); in_rd = 5'($urandom);
    if (e.err) begin
      chk({tag, ".err_req_valid"}, mem_req_valid, 0);
      chk({tag, ".err_out_valid"}, out_valid, 1);
      chk({tag, ".err_out_err"}, out_err, 1);
      chk({tag, ".err_out_we"}, out_we, 0);
      chk({tag, ".err_out_data"}, out_data, 0);
      chk({tag, ".err_out_rd"}, out_rd, rd);
    end else begin
      for (int k = 0; k <= req_lat; k++) begin
        chk({tag, ".req_valid"}, mem_req_valid, 1);
        chk({tag, ".busy_in_ready"}, in_ready, 0);
        chk({tag, ".mem_addr"}, mem_addr, e.mem_addr);
        chk({tag, ".mem_wen"}, mem_wen, f[3]);
        chk({tag, ".mem_wmask"}, mem_wmask, e.wmask);
        if (f[3]) chk({tag, ".mem_wdata"}, mem_wdata, e.wdata);
        if (k == req_lat) mem_req_ready = 1'b1;
        tick();
      end
      mem_req_ready = 1'b0;
      chk({tag, ".wait_req_valid"}, mem_req_valid, 0);
      for (int k = 0; k <= rsp_lat; k++) begin
        chk({tag, ".wait_out_valid"}, out_valid, 0);
        if (k == rsp_lat) begin
          mem_rsp_valid = 1'b1;
          mem_rdata = rdata;
        end
        tick();
      end
      mem_rsp_valid = 1'b0;
      mem_rdata = $urandom;
      chk({tag, ".out_err"}, out_err, 0);
    end
    for (int k = 0; k <= out_lat; k++) begin
      chk({tag, ".out_valid"}, out_valid, 1);
      chk({tag, ".out_data"}, out_data, e.data);
      chk({tag, ".out_we"}, out_we, e.we);
      chk({tag, ".out_rd"}, out_rd, rd);
      if (k == out_lat) out_ready = 1'b1;
      tick();
    end
    out_ready = 1'b0;
    chk({tag, ".after_out_valid"}, out_valid, 0);
    chk({tag, ".after_in_ready"}, in_ready, 1);
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, ".in_ready"}, in_ready, 1);
    chk({tag, ".mem_req_valid"}, mem_req_valid, 0);
    chk({tag, ".mem_addr"}, mem_addr, 0);
    chk({tag, ".mem_wen"}, mem_wen, 0);
    chk({tag, ".mem_wmask"}, mem_wmask, 0);
    chk({tag, ".mem_wdata"}, mem_wdata, 0);
    chk({tag, ".out_valid"}, out_valid, 0);
    chk({tag, ".out_data"}, out_data, 0);
    chk({tag, ".out_rd"}, out_rd, 0);
    chk({tag, ".out_we"}, out_we, 0);
    chk({tag, ".out_err"}, out_err, 0);
  endtask

  vec_t  tbl[10];
  exp_t  e;
  logic [31:0] ra, rwd, rrd;
  logic [3:0]  rf;

  initial begin
    tbl[0] = '{32'h8000_0003, 32'h0, 4'b0000, 5'd1, 32'h80FF_1234,
               '{32'h8000_0000, 4'b0000, 32'h0, 32'hFFFF_FF80, 1'b1, 1'b0}, 0, 0};
    tbl[1] = '{32'h8000_0006, 32'h0000_ABCD, 4'b1001, 5'd2, 32'h5555_AAAA,
               '{32'h8000_0004, 4'b1100, 32'hABCD_ABCD, 32'h0, 1'b0, 1'b0}, 0, 0};
    tbl[2] = '{32'h0000_0002, 32'h0, 4'b0101, 5'd3, 32'h9876_5432,
               '{32'h0000_0000, 4'b0000, 32'h0, 32'h0000_9876, 1'b1, 1'b0}, 3, 2};
    tbl[3] = '{32'h0000_0101, 32'h1234_56EF, 4'b1000, 5'd4, 32'h0,
               '{32'h0000_0100, 4'b0010, 32'hEFEF_EFEF, 32'h0, 1'b0, 1'b0}, 1, 0};
    tbl[4] = '{32'h0000_0010, 32'h0, 4'b0001, 5'd5, 32'h1234_8001,
               '{32'h0000_0010, 4'b0000, 32'h0, 32'hFFFF_8001, 1'b1, 1'b0}, 0, 1};
    tbl[5] = '{32'h0000_0022, 32'h0, 4'b0100, 5'd6, 32'h00AB_0000,
               '{32'h0000_0020, 4'b0000, 32'h0, 32'h0000_00AB, 1'b1, 1'b0}, 0, 0};
    tbl[6] = '{32'h0000_0044, 32'h0, 4'b0010, 5'd7, 32'hDEAD_BEEF,
               '{32'h0000_0044, 4'b0000, 32'h0, 32'hDEAD_BEEF, 1'b1, 1'b0}, 0, 0};
    tbl[7] = '{32'h0000_0048, 32'hCAFE_F00D, 4'b1010, 5'd8, 32'h0,
               '{32'h0000_0048, 4'b1111, 32'hCAFE_F00D, 32'h0, 1'b0, 1'b0}, 0, 0};
    tbl[8] = '{32'h0000_0050, 32'h0, 4'b0011, 5'd9, 32'h89AB_CDEF,
               '{32'h0000_0050, 4'b0000, 32'h0, 32'h89AB_CDEF, 1'b1, 1'b0}, 0, 0};
    tbl[9] = '{32'h0000_0007, 32'h0, 4'b0000, 5'd31, 32'h7F00_0000,
               '{32'h0000_0004, 4'b0000, 32'h0, 32'h0000_007F, 1'b1, 1'b0}, 2, 0};

    #1 rst_n = 1'b0;
    #10;
    chk_reset_values("reset");
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 10; i++) begin
      do_txn($sformatf("vec%0d", i), tbl[i].a, tbl[i].wd, tbl[i].f, tbl[i].rd, tbl[i].rdata,
             tbl[i].e, tbl[i].req_lat, 0, tbl[i].out_lat);
    end

    // Stale response while idle must be ignored.
    mem_rsp_valid = 1'b1; mem_rdata = 32'h1111_1111;
    tick();
    mem_rsp_valid = 1'b0;
    chk("stale.out_valid", out_valid, 0);
    chk("stale.in_ready", in_ready, 1);

    // Reset while waiting for the response, then a late response.
    in_valid = 1'b1; in_addr = 32'h0000_0208; in_func = 4'b0010; in_rd = 5'd12;
    tick();
    in_valid = 1'b0;
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    chk("rstwait.in_wait_req_valid", mem_req_valid, 0);
    rst_n = 1'b0;
    #2;
    chk_reset_values("rstwait.async");
    #2 rst_n = 1'b1;
    tick();
    mem_rsp_valid = 1'b1; mem_rdata = 32'h2222_3333;
    tick();
    mem_rsp_valid = 1'b0;
    chk_reset_values("rstwait.late_rsp");
    tick();
    chk("rstwait.settled_out_valid", out_valid, 0);

    // Misaligned accesses.
`ifdef LSU_MISALIGN_TRAP_EN
    e = '{32'h0, 4'b0000, 32'h0, 32'h0, 1'b0, 1'b1};
    do_txn("mis_lw", 32'h0000_0001, 32'h0, 4'b0010, 5'd10, 32'h1122_3344, e, 0, 0, 1);
    do_txn("mis_sh", 32'h0000_0003, 32'hBEEF, 4'b1001, 5'd11, 32'h0, e, 0, 0, 0);
`else
    e = '{32'h0, 4'b0000, 32'h0, 32'h1122_3344, 1'b1, 1'b0};
    do_txn("mis_lw", 32'h0000_0001, 32'h0, 4'b0010, 5'd10, 32'h1122_3344, e, 0, 0, 0);
    e = '{32'h0, 4'b0000, 32'h0, 32'hFFFF_F00D, 1'b1, 1'b0};
    do_txn("mis_lh", 32'h0000_0003, 32'h0, 4'b0001, 5'd13, 32'hF00D_1234, e, 0, 0, 0);
    e = '{32'h0, 4'b1100, 32'hBEEF_BEEF, 32'h0, 1'b0, 1'b0};
    do_txn("mis_sh", 32'h0000_0003, 32'h0000_BEEF, 4'b1001, 5'd11, 32'h0, e, 0, 0, 0);
`endif

    for (int i = 0; i < 60; i++) begin
      ra = $urandom;
      rwd = $urandom;
      rrd = $urandom;
      rf = 4'($urandom_range(0, 15));
      e = model(ra, rwd, rf, rrd);
      do_txn($sformatf("rnd%0d", i), ra, rwd, rf, 5'($urandom), rrd, e,
             $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lsu_stage.md
# lsu_stage

Load/store stage sitting directly downstream of the execute stage in the NPC core. It takes the ALU result as an effective address, plus the rs2 value and a memory-op code, and performs one byte, half-word or word access over a simple request/response data-memory bus. Load data is aligned and sign/zero-extended; stores are lane-shifted and masked. The result is handed to writeback through a valid/ready handshake. One access is in flight at a time.

## Interface
Parameters:
- none; data and address widths are fixed at 32 bits.

Ports:
- clk  input  1  core clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  execute stage presents an access
- in_ready  output  1  stage can accept; high only in IDLE
- in_addr  input  32  effective address (execute-stage ALU output)
- in_wdata  input  32  store data (rs2 value)
- in_func  input  4  [3]=store, [2]=unsigned load, [1:0] size: 00 byte, 01 half, 10 word, 11 reserved (treated as word)
- in_rd  input  5  destination register, passed through
- mem_req_valid  output  1  bus request valid
- mem_req_ready  input  1  bus accepts request
- mem_addr  output  32  word-aligned address (addr & ~3)
- mem_wen  output  1  1 = write
- mem_wmask  output  4  byte-lane enables (write only; 0 for reads)
- mem_wdata  output  32  store data shifted into lanes
- mem_rsp_valid  input  1  one-cycle response/ack, no backpressure
- mem_rdata  input  32  read word
- out_valid  output  1  result for writeback
- out_ready  input  1  writeback accepts
- out_data  output  32  extended load data; 0 for stores
- out_rd  output  5  latched in_rd
- out_we  output  1  1 for a completed load (regfile write), 0 for stores/errors
- out_err  output  1  misaligned access (only with trap feature)

## Operation
- States: IDLE, REQ, WAIT, DONE.
- IDLE: in_ready=1. in_valid latches addr, wdata, func, rd; next state REQ (or DONE with error, see Configuration).
- REQ: mem_req_valid=1 with registered fields; stays until mem_req_ready, then WAIT.
- WAIT: on mem_rsp_valid, loads capture mem_rdata, select lane by addr[1:0] (byte: addr[1:0]; half: addr[1]), extend per func[2]; stores ignore rdata. Next DONE.
- DONE: out_valid=1, holds all out_* stable until out_ready; then IDLE.
- Store lanes: byte mask 4'b0001<<addr[1:0], data replicated {4{b}}; half mask 4'b0011<<{addr[1],1'b0}, data {2{h}}; word mask 4'b1111.
- mem_rsp_valid outside WAIT is ignored (covers stale responses after reset).
- Reset (any state, async): state IDLE, all registers cleared; in-flight bus transaction abandoned.

## Timing
- Reset values: in_ready=1, mem_req_valid=0, mem_addr=0, mem_wen=0, mem_wmask=0, mem_wdata=0, out_valid=0, out_data=0, out_rd=0, out_we=0, out_err=0.
- Minimum latency: accept cycle 0, request cycle 1 (ready same cycle), rsp cycle 2, out_valid cycle 3.
- No accept while busy; in_ready low REQ..DONE, IDLE re-entered the cycle after out_ready; back-to-back throughput 1 per 4 cycles minimum.
- mem_* outputs registered and held stable while mem_req_valid && !mem_req_ready.

## Configuration
- LSU_MISALIGN_TRAP_EN defined: half access with addr[0]=1 or word access with addr[1:0]!=0 issues no bus request; IDLE -> DONE, out_err=1, out_we=0, out_data=0, out_valid at cycle 1.
- Undefined: no check; out_err tied 0; misaligned low bits select lanes as if naturally aligned (half uses addr[1], word ignores addr[1:0]).

## Test plan
- Load lb addr 0x80000003, rdata 0x80FF_1234 -> mem_addr 0x80000000, out_data 0xFFFFFF80, out_we=1, out_valid at cycle 3.
- sh addr 0x80000006, wdata 0x0000ABCD -> mem_wen=1, mem_wmask 4'b1100, mem_wdata 0xABCDABCD, out_we=0.
- lhu addr 0x2, rdata 0x9876_5432, mem_req_ready low 3 cycles, out_ready low 2 cycles -> request held stable, out_data 0x00009876 held until accepted.
- rst_n pulsed low in WAIT, then mem_rsp_valid arrives -> all outputs reset values, response ignored, in_ready=1.
- With LSU_MISALIGN_TRAP_EN, lw addr 0x1 -> no mem_req_valid, out_err=1 at cycle 1; without, same op reads word 0x0.
